hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage core. It sits beside the forwarding unit and sequences the whole pipeline. It holds the PC and IF/ID register and injects an ID/EX bubble on load-use hazards, flushes IF/ID on taken branches, and freezes every pipeline register while the data memory is busy. It also runs a memory-wait watchdog and optional hazard performance counters.

---
 rtl/hazard_pkg.sv | 31 +++
 rtl/hazard_wait_timer.sv | 31 +++
 rtl/hazard_ctrl.sv | 116 +++++++++++
 tb/tb_hazard_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM states,
// counter width and the prioritised stall-cause encoding.
package hazard_pkg;

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_t;

    localparam int CNT_W = 32;

    typedef enum logic [1:0] {
        NONE,
        MEM,
        LOAD_USE,
        FLUSH
    } cause_t;

    // Memory stall beats load-use, which beats a taken branch.
    function automatic cause_t stallCause(
        input logic memStall,
        input logic loadUse,
        input logic branch
    );
        if (memStall) return MEM;
        else if (loadUse) return LOAD_USE;
        else if (branch) return FLUSH;
        else return NONE;
    endfunction

endpackage

// File: rtl/hazard_wait_timer.sv
// Saturating memory-wait counter with a sticky timeout flag.
// The flag can only be cleared by reset.
module hazard_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic countEn,
    output logic timeout
);
    import hazard_pkg::*;

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] waitCnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            waitCnt <= '0;
            timeout <= 1'b0;
        end else if (clear) begin
            waitCnt <= '0;
        end else if (countEn) begin
            if (waitCnt != LIMIT) waitCnt <= waitCnt + 16'd1;
            // Flag lands on the same edge the count reaches the limit.
            if (waitCnt >= LIMIT - 16'd1) timeout <= 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall sequencer: memory freeze, load-use bubble, branch flush.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  IF_ID_RsAddr_i,
    input  logic [4:0]  IF_ID_RtAddr_i,
    input  logic        ID_EX_MemRead_i,
    input  logic [4:0]  ID_EX_RtAddr_i,
    input  logic        Branch_Taken_i,
    input  logic        MEM_Access_i,
    input  logic        Mem_Ready_i,
    output logic        PC_Write_o,
    output logic        IF_ID_Write_o,
    output logic        IF_ID_Flush_o,
    output logic        ID_EX_Bubble_o,
    output logic        Stall_o,
    output logic        Mem_Timeout_o,
    output logic [31:0] LoadUse_Cnt_o,
    output logic [31:0] MemStall_Cnt_o,
    output logic [31:0] Flush_Cnt_o
);
    import hazard_pkg::*;

    state_t state;
    cause_t cause;
    logic   memStall;
    logic   loadUse;

    assign memStall = (state == RUN) ? (MEM_Access_i && !Mem_Ready_i)
                                     : !Mem_Ready_i;

    assign loadUse = ID_EX_MemRead_i && (ID_EX_RtAddr_i != 5'd0) &&
                     ((ID_EX_RtAddr_i == IF_ID_RsAddr_i) ||
                      (ID_EX_RtAddr_i == IF_ID_RtAddr_i));

    assign cause = stallCause(memStall, loadUse, Branch_Taken_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= RUN;
        end else begin
            unique case (state)
                RUN:      if (memStall) state <= MEM_WAIT;
                MEM_WAIT: if (Mem_Ready_i) state <= RUN;
            endcase
        end
    end

    always_comb begin
        PC_Write_o     = 1'b0;
        IF_ID_Write_o  = 1'b0;
        IF_ID_Flush_o  = 1'b0;
        ID_EX_Bubble_o = 1'b0;
        Stall_o        = 1'b0;
        // Everything stays low while reset is held.
        if (rst_i) begin
            unique case (cause)
                MEM: begin
                    Stall_o = 1'b1;
                end
                LOAD_USE: begin
                    ID_EX_Bubble_o = 1'b1;
                end
                FLUSH: begin
                    PC_Write_o    = 1'b1;
                    IF_ID_Write_o = 1'b1;
                    IF_ID_Flush_o = 1'b1;
                end
                NONE: begin
                    PC_Write_o    = 1'b1;
                    IF_ID_Write_o = 1'b1;
                end
            endcase
        end
    end

    hazard_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear  ((state == RUN) && memStall),
        .countEn((state == MEM_WAIT) && !Mem_Ready_i),
        .timeout(Mem_Timeout_o)
    );

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] luCnt;
    logic [CNT_W-1:0] msCnt;
    logic [CNT_W-1:0] flCnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            luCnt <= '0;
            msCnt <= '0;
            flCnt <= '0;
        end else begin
            luCnt <= luCnt + CNT_W'(ID_EX_Bubble_o);
            msCnt <= msCnt + CNT_W'(Stall_o);
            flCnt <= flCnt + CNT_W'(IF_ID_Flush_o);
        end
    end

    assign LoadUse_Cnt_o  = luCnt;
    assign MemStall_Cnt_o = msCnt;
    assign Flush_Cnt_o    = flCnt;
`else
    assign LoadUse_Cnt_o  = '0;
    assign MemStall_Cnt_o = '0;
    assign Flush_Cnt_o    = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a behavioural reference model.
// TIMEOUT_CYCLES is set to 4 so the watchdog trips quickly.
module tb_hazard_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [4:0]  rs, rt, exRt;
    logic        memRead, branch, access, ready;
    logic        pcW, ifW, flush, bubble, stall, tmo;
    logic [31:0] luCnt, msCnt, flCnt;
    logic [4:0]  ctl;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit          mBusy;
    int          mWaited;
    bit          mTimeout;
    logic [31:0] mLu, mMs, mFl;
    logic [4:0]  mE;

    always #5 clk = ~clk;

    hazard_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .IF_ID_RsAddr_i (rs),
        .IF_ID_RtAddr_i (rt),
        .ID_EX_MemRead_i(memRead),
        .ID_EX_RtAddr_i (exRt),
        .Branch_Taken_i (branch),
        .MEM_Access_i   (access),
        .Mem_Ready_i    (ready),
        .PC_Write_o     (pcW),
        .IF_ID_Write_o  (ifW),
        .IF_ID_Flush_o  (flush),
        .ID_EX_Bubble_o (bubble),
        .Stall_o        (stall),
        .Mem_Timeout_o  (tmo),
        .LoadUse_Cnt_o  (luCnt),
        .MemStall_Cnt_o (msCnt),
        .Flush_Cnt_o    (flCnt)
    );

    assign ctl = {pcW, ifW, flush, bubble, stall};

    // {PC_Write, IF_ID_Write, Flush, Bubble, Stall}
    function automatic logic [4:0] expCtl(input bit busy);
        bit memHold, hazard;
        if (!rst_i) return 5'b00000;
        memHold = !ready && (busy || access);
        hazard  = memRead && exRt != 0 && (exRt == rs || exRt == rt);
        if (memHold) return 5'b00001;
        if (hazard)  return 5'b00010;
        if (branch)  return 5'b11100;
        return 5'b11000;
    endfunction

    always @(posedge clk) begin
        if (!rst_i) begin
            mBusy = 0; mWaited = 0; mTimeout = 0;
            mLu = 0; mMs = 0; mFl = 0;
        end else begin
            mE  = expCtl(mBusy);
            mLu = mLu + 32'(mE[1]);
            mMs = mMs + 32'(mE[0]);
            mFl = mFl + 32'(mE[2]);
            if (!mBusy) begin
                if (access && !ready) begin
                    mBusy = 1; mWaited = 0;
                end
            end else if (ready) begin
                mBusy = 0;
            end else begin
                if (mWaited < TO) mWaited++;
                if (mWaited == TO) mTimeout = 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [4:0]  e;
        logic [31:0] eLu, eMs, eFl;
        bit          eT;
        e  = expCtl(mBusy);
        eT = rst_i && mTimeout;
`ifdef HAZARD_PERF_CNT_EN
        eLu = rst_i ? mLu : 32'd0;
        eMs = rst_i ? mMs : 32'd0;
        eFl = rst_i ? mFl : 32'd0;
`else
        eLu = 0; eMs = 0; eFl = 0;
`endif
        checks++;
        if (ctl !== e || tmo !== eT || luCnt !== eLu ||
            msCnt !== eMs || flCnt !== eFl) begin
            errors++;
            $display("FAIL model t=%0t ctl=%b/%b tmo=%b/%b cnt=%0d,%0d,%0d/%0d,%0d,%0d",
                     $time, ctl, e, tmo, eT, luCnt, msCnt, flCnt, eLu, eMs, eFl);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic acc, input logic rdy,
                         input logic mr, input logic [4:0] er,
                         input logic [4:0] s, input logic [4:0] t,
                         input logic br);
        access = acc; ready = rdy; memRead = mr;
        exRt = er; rs = s; rt = t; branch = br;
        #1;
    endtask

    task automatic nextCyc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        nextCyc();
        chk("reset_ctl", 32'(ctl), 0);
        chk("reset_tmo", 32'(tmo), 0);
        nextCyc();

        rst_i = 1'b1;
        drive(0, 1, 0, 0, 0, 0, 0);
        chk("idle", 32'(ctl), 32'b11000);
        nextCyc();

        drive(0, 1, 1, 5, 5, 0, 0);
        chk("loaduse_rs", 32'(ctl), 32'b00010);
        nextCyc();
        drive(0, 1, 0, 5, 5, 0, 0);
        chk("loaduse_done", 32'(ctl), 32'b11000);
        nextCyc();
        drive(0, 1, 1, 0, 0, 0, 0);
        chk("rt0_nobubble", 32'(ctl), 32'b11000);
        nextCyc();

        drive(0, 1, 1, 7, 0, 7, 1);
        chk("lu_defers_br", 32'(ctl), 32'b00010);
        nextCyc();
        drive(0, 1, 0, 7, 0, 7, 1);
        chk("br_flush", 32'(ctl), 32'b11100);
        nextCyc();

        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 5, 5, 0, 1);
            chk("memstall", 32'(ctl), 32'b00001);
            nextCyc();
        end
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("ready_nostall", 32'(ctl), 32'b11000);
        nextCyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("run_after_ready", 32'(ctl), 32'b11000);
        nextCyc();

        drive(1, 0, 0, 0, 0, 0, 0);
        chk("wd_entry", 32'(ctl), 32'b00001);
        chk("wd_entry_tmo", 32'(tmo), 0);
        nextCyc();
        for (int i = 1; i <= 6; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            chk("wd_stall", 32'(ctl), 32'b00001);
            chk($sformatf("wd_tmo_%0d", i), 32'(tmo), (i >= 5) ? 1 : 0);
            nextCyc();
        end
        drive(0, 1, 0, 0, 0, 0, 0);
        chk("wd_ready_ctl", 32'(ctl), 32'b11000);
        chk("wd_sticky", 32'(tmo), 1);
        nextCyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("wd_sticky2", 32'(tmo), 1);
        nextCyc();

        drive(1, 0, 0, 0, 0, 0, 0);
        nextCyc();
        drive(1, 0, 0, 0, 0, 0, 0);
        nextCyc();
        rst_i = 1'b0;
        #1;
        chk("rst_mid_ctl", 32'(ctl), 0);
        chk("rst_mid_tmo", 32'(tmo), 0);
        nextCyc();
        rst_i = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("rst_release", 32'(ctl), 32'b11000);
        nextCyc();

        drive(0, 1, 1, 5, 5, 0, 0);
        nextCyc();
        drive(0, 1, 1, 9, 0, 9, 0);
        nextCyc();
        drive(0, 1, 0, 0, 0, 0, 1);
        nextCyc();
        drive(1, 0, 0, 0, 0, 0, 0);
        nextCyc();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            nextCyc();
        end
        drive(0, 1, 0, 0, 0, 0, 0);
        nextCyc();
        drive(0, 1, 0, 0, 0, 0, 0);
`ifdef HAZARD_PERF_CNT_EN
        chk("cnt_lu", luCnt, 2);
        chk("cnt_ms", msCnt, 5);
        chk("cnt_fl", flCnt, 1);
`else
        chk("cnt_lu", luCnt, 0);
        chk("cnt_ms", msCnt, 0);
        chk("cnt_fl", flCnt, 0);
`endif
        nextCyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
